// File: rtl/mux_pkg.sv
// Purpose : shared constants and types for the stream mux family.
// Latency : n/a (package only).
// Backpr. : n/a (package only).
//
// Contents: mode encodings, counter width, output-stage state type, and a
// clog2 helper for tools without $clog2.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  localparam int CNT_W = 16;

  typedef enum logic {
    OST_EMPTY = 1'b0,
    OST_FULL  = 1'b1
  } ost_e;

  // Ceiling log2. Returns 0 for n <= 1.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_rr_stream_rr_pick.sv
// Purpose : rotate-priority picker, returns the first requester at or after ptr.
// Latency : purely combinational.
// Backpr. : none; the caller qualifies the grant with its own load condition.
//
// Ports: req     - request vector, one bit per channel
//        ptr     - search start position (must be < NCH)
//        gnt_idx - index of the winning channel (0 when none)
//        gnt_any - at least one request present
module rr_pick
  import mux_pkg::*;
#(
  parameter int  NCH  = 4,
  localparam int SELW = clog2(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] gnt_idx,
  output logic            gnt_any
);

  always_comb begin : pick_search
    int pos;
    pos     = 0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    // Walk from the farthest position back towards ptr so the nearest
    // requester (in wrap order) is the one left standing.
    for (int k = NCH - 1; k >= 0; k--) begin
      pos = int'(ptr) + k;
      // ptr < NCH and k < NCH, so one subtraction is enough for the wrap.
      if (pos >= NCH) pos = pos - NCH;
      if (req[SELW'(pos)]) begin
        gnt_idx = SELW'(pos);
        gnt_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_rr_stream.sv
// Purpose : N-channel valid/ready stream mux, fixed-select or round-robin.
// Latency : 1 cycle (single registered output stage), 1 beat/cycle.
// Backpr. : in_ready drops while the output register is full and out_ready=0.
//
// Ports: clk, rst_n                      - clock, async active-low reset
//        in_valid/in_data/in_ready       - per-channel inputs, ch i at [i*W +: W]
//        mode, sel                       - 0 = fixed (sel), 1 = round-robin
//        out_valid/out_data/out_ch       - registered output beat and source index
//        out_ready                       - consumer ready
//        beat_cnt                        - per-channel saturating 16-bit transfer
//                                          counts, only with MUX_RR_STREAM_CNT_EN
module mux_rr_stream
  import mux_pkg::*;
#(
  parameter int  NCH  = 4,
  parameter int  W    = 8,
  localparam int SELW = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH-1:0]       in_valid,
  input  logic [NCH*W-1:0]     in_data,
  output logic [NCH-1:0]       in_ready,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  output logic                 out_valid,
  output logic [W-1:0]         out_data,
  output logic [SELW-1:0]      out_ch,
  input  logic                 out_ready
`ifdef MUX_RR_STREAM_CNT_EN
  ,
  output logic [NCH*CNT_W-1:0] beat_cnt
`endif
);

  ost_e            state_q, state_d;
  logic [SELW-1:0] ptr_q;
  logic [SELW-1:0] rr_idx;
  logic            rr_any;
  logic [SELW-1:0] grant;
  logic            gvalid;
  logic            fix_vld;
  logic [W-1:0]    gdata;
  logic            load;
  logic            xfer;

  rr_pick #(.NCH(NCH)) u_rr_pick (
    .req     (in_valid),
    .ptr     (ptr_q),
    .gnt_idx (rr_idx),
    .gnt_any (rr_any)
  );

  // Grant selection. An out-of-range sel matches no channel, so fix_vld
  // stays low and nothing is ever made ready.
  always_comb begin
    fix_vld = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (sel == SELW'(i)) fix_vld = in_valid[i];
    end
    if (mode == MODE_FIXED) begin
      grant  = sel;
      gvalid = fix_vld;
    end else begin
      grant  = rr_idx;
      gvalid = rr_any;
    end
  end

  always_comb begin
    gdata = '0;
    for (int i = 0; i < NCH; i++) begin
      if (grant == SELW'(i)) gdata = in_data[i*W +: W];
    end
  end

  // Accept whenever the register is empty or being drained this cycle.
  assign load = !out_valid || out_ready;
  // gvalid already implies in_valid[grant], so this is the handshake itself.
  assign xfer = load && gvalid;

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < NCH; i++) begin
      in_ready[i] = xfer && (grant == SELW'(i));
    end
  end

  // Output-stage FSM: state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= OST_EMPTY;
    else        state_q <= state_d;
  end

  // Output-stage FSM: next state. Without load the register holds.
  always_comb begin
    state_d = state_q;
    if (load) state_d = xfer ? OST_FULL : OST_EMPTY;
  end

  // Output-stage FSM: outputs.
  always_comb begin
    out_valid = (state_q == OST_FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      out_ch   <= '0;
    end else if (xfer) begin
      out_data <= gdata;
      out_ch   <= grant;
    end
  end

  // Pointer only advances on a round-robin transfer; switching modes keeps it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (xfer && (mode == MODE_RR)) begin
      ptr_q <= (grant == SELW'(NCH - 1)) ? '0 : grant + SELW'(1);
    end
  end

`ifdef MUX_RR_STREAM_CNT_EN
  for (genvar i = 0; i < NCH; i++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else if (in_valid[i] && in_ready[i] && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
    assign beat_cnt[i*CNT_W +: CNT_W] = cnt_q;
  end
`endif

endmodule

// File: tb/tb_mux_rr_stream.sv
module tb_mux_rr_stream;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // 4-channel instance
  logic [3:0]  v4, rdy4;
  logic [31:0] d4;
  logic        m4, or4, ov4;
  logic [1:0]  s4, oc4;
  logic [7:0]  od4;
  // 3-channel instance
  logic [2:0]  v3, rdy3;
  logic [23:0] d3;
  logic        m3, or3, ov3;
  logic [1:0]  s3, oc3;
  logic [7:0]  od3;
`ifdef MUX_RR_STREAM_CNT_EN
  logic [63:0] cnt4;
  logic [47:0] cnt3;
`endif

  mux_rr_stream #(.NCH(4), .W(8)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_data(d4), .in_ready(rdy4),
    .mode(m4), .sel(s4), .out_valid(ov4), .out_data(od4), .out_ch(oc4),
    .out_ready(or4)
`ifdef MUX_RR_STREAM_CNT_EN
    , .beat_cnt(cnt4)
`endif
  );

  mux_rr_stream #(.NCH(3), .W(8)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(v3), .in_data(d3), .in_ready(rdy3),
    .mode(m3), .sel(s3), .out_valid(ov3), .out_data(od3), .out_ch(oc3),
    .out_ready(or3)
`ifdef MUX_RR_STREAM_CNT_EN
    , .beat_cnt(cnt3)
`endif
  );

  // ---------------- reference model (index 0 = 4ch, 1 = 3ch) ----------------
  bit         e_valid[2];
  logic [7:0] e_data[2];
  int         e_ch[2];
  int         e_ptr[2];

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      e_valid[k] = 0; e_data[k] = 8'h00; e_ch[k] = 0; e_ptr[k] = 0;
    end
  endfunction

  function automatic void get_in(input int k, output bit md, output int s,
                                 output logic [15:0] v, output logic [127:0] d,
                                 output bit ordy);
    if (k == 0) begin
      md = m4; s = int'(s4); v = 16'(v4); d = 128'(d4); ordy = or4;
    end else begin
      md = m3; s = int'(s3); v = 16'(v3); d = 128'(d3); ordy = or3;
    end
  endfunction

  // Who would be granted right now, whether it is grantable, and whether the
  // output register can take a beat this cycle.
  function automatic void ref_grant(input int k, output int g, output bit gv,
                                    output bit ld, output bit md,
                                    output logic [127:0] d);
    int nch, s;
    logic [15:0] v;
    bit ordy;
    nch = (k == 0) ? 4 : 3;
    get_in(k, md, s, v, d, ordy);
    ld = !e_valid[k] || ordy;
    g = 0; gv = 0;
    if (!md) begin
      g = s;
      gv = (s < nch) && v[s];
    end else begin
      for (int j = 0; j < nch; j++) begin
        int i;
        i = (e_ptr[k] + j) % nch;
        if (!gv && v[i]) begin gv = 1; g = i; end
      end
    end
  endfunction

  function automatic logic [15:0] exp_rdy(input int k);
    int g; bit gv, ld, md; logic [127:0] d;
    ref_grant(k, g, gv, ld, md, d);
    return (ld && gv) ? (16'h1 << g) : 16'h0;
  endfunction

  // Advance both models across one rising edge, then settle 1 time unit.
  task automatic tick();
    int g[2]; bit gv[2], ld[2], md[2]; logic [127:0] dd[2];
    for (int k = 0; k < 2; k++) ref_grant(k, g[k], gv[k], ld[k], md[k], dd[k]);
    @(posedge clk);
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        int nch;
        nch = (k == 0) ? 4 : 3;
        if (ld[k]) begin
          if (gv[k]) begin
            e_valid[k] = 1;
            e_data[k] = dd[k][g[k]*8 +: 8];
            e_ch[k] = g[k];
            if (md[k]) e_ptr[k] = (g[k] == nch - 1) ? 0 : g[k] + 1;
          end else begin
            e_valid[k] = 0;
          end
        end
      end
    end
    #1;
  endtask

  // ------------------------------- tests ------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    v4 = '0; d4 = '0; m4 = 0; s4 = '0; or4 = 0;
    v3 = '0; d3 = '0; m3 = 0; s3 = '0; or3 = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ov4 !== 1'b0) begin errors++; $display("FAIL reset_ov4: got %b expected 0", ov4); end
    checks++; if (od4 !== 8'h00) begin errors++; $display("FAIL reset_od4: got %h expected 00", od4); end
    checks++; if (oc4 !== 2'd0) begin errors++; $display("FAIL reset_oc4: got %0d expected 0", oc4); end
    checks++; if (ov3 !== 1'b0) begin errors++; $display("FAIL reset_ov3: got %b expected 0", ov3); end
    checks++; if (od3 !== 8'h00) begin errors++; $display("FAIL reset_od3: got %h expected 00", od3); end
    checks++; if (oc3 !== 2'd0) begin errors++; $display("FAIL reset_oc3: got %0d expected 0", oc3); end
    rst_n = 1'b1;
  endtask

  task automatic test_fixed();
    m4 = 0; s4 = 2'd2; v4 = 4'hF; d4 = 32'h44A52211; or4 = 1;
    #1;
    checks++; if (rdy4 !== 4'b0100) begin errors++; $display("FAIL fixed_rdy: got %b expected 0100", rdy4); end
    tick();
    checks++; if (ov4 !== 1'b1) begin errors++; $display("FAIL fixed_ov: got %b expected 1", ov4); end
    checks++; if (od4 !== 8'hA5) begin errors++; $display("FAIL fixed_od: got %h expected a5", od4); end
    checks++; if (oc4 !== 2'd2) begin errors++; $display("FAIL fixed_oc: got %0d expected 2", oc4); end
  endtask

  task automatic test_rr_fair();
    logic [15:0] er;
    m4 = 1; v4 = 4'hF; or4 = 1;
    for (int c = 0; c < 8; c++) begin
      d4 = $urandom;
      #1;
      er = exp_rdy(0);
      checks++; if (rdy4 !== er[3:0]) begin errors++; $display("FAIL fair_rdy[%0d]: got %b expected %b", c, rdy4, er[3:0]); end
      tick();
      checks++; if (oc4 !== 2'(c % 4)) begin errors++; $display("FAIL fair_ch[%0d]: got %0d expected %0d", c, oc4, c % 4); end
      checks++; if (od4 !== e_data[0]) begin errors++; $display("FAIL fair_data[%0d]: got %h expected %h", c, od4, e_data[0]); end
    end
  endtask

  task automatic test_sparse();
    int seq[4] = '{0, 3, 0, 3};
    m4 = 1; v4 = 4'b1001; or4 = 1;
    for (int c = 0; c < 4; c++) begin
      d4 = $urandom;
      tick();
      checks++; if (oc4 !== 2'(seq[c])) begin errors++; $display("FAIL sparse_ch[%0d]: got %0d expected %0d", c, oc4, seq[c]); end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] er;
    m4 = 0; s4 = 2'd1; v4 = 4'b0010; d4 = 32'h00003C00; or4 = 1;
    tick();
    or4 = 0; m4 = 1;
    for (int c = 0; c < 3; c++) begin
      v4 = 4'($urandom_range(1, 15)); d4 = $urandom;
      #1;
      checks++; if (rdy4 !== 4'b0000) begin errors++; $display("FAIL bp_rdy[%0d]: got %b expected 0000", c, rdy4); end
      checks++; if (ov4 !== 1'b1 || od4 !== 8'h3C) begin errors++; $display("FAIL bp_hold[%0d]: got %b/%h expected 1/3c", c, ov4, od4); end
      tick();
    end
    or4 = 1; v4 = 4'hF; d4 = $urandom;
    #1;
    er = exp_rdy(0);
    checks++; if (rdy4 !== er[3:0] || rdy4 !== 4'b0001) begin errors++; $display("FAIL bp_release_rdy: got %b expected 0001", rdy4); end
    checks++; if (od4 !== 8'h3C) begin errors++; $display("FAIL bp_release_hold: got %h expected 3c", od4); end
    tick();
    checks++; if (ov4 !== 1'b1 || oc4 !== 2'd0 || od4 !== e_data[0]) begin
      errors++; $display("FAIL bp_new_beat: got %b/%0d/%h expected 1/0/%h", ov4, oc4, od4, e_data[0]);
    end
  endtask

  task automatic test_nch3();
    v4 = '0; or4 = 1;
    m3 = 1; v3 = 3'b100; or3 = 1; d3 = $urandom;
    #1;
    checks++; if (rdy3 !== 3'b100) begin errors++; $display("FAIL n3_rdy_ch2: got %b expected 100", rdy3); end
    tick();
    checks++; if (ov3 !== 1'b1 || oc3 !== 2'd2 || od3 !== e_data[1]) begin
      errors++; $display("FAIL n3_beat_ch2: got %b/%0d/%h expected 1/2/%h", ov3, oc3, od3, e_data[1]);
    end
    v3 = 3'b011; d3 = $urandom;
    #1;
    checks++; if (rdy3 !== 3'b001) begin errors++; $display("FAIL n3_wrap_rdy: got %b expected 001", rdy3); end
    tick();
    checks++; if (oc3 !== 2'd0) begin errors++; $display("FAIL n3_wrap_ch: got %0d expected 0", oc3); end
    m3 = 0; s3 = 2'd3; v3 = 3'b111;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++; if (rdy3 !== 3'b000) begin errors++; $display("FAIL n3_badsel_rdy[%0d]: got %b expected 000", c, rdy3); end
      tick();
      checks++; if (ov3 !== 1'b0) begin errors++; $display("FAIL n3_badsel_ov[%0d]: got %b expected 0", c, ov3); end
    end
  endtask

  task automatic test_random();
    logic [15:0] e4, e3;
    for (int c = 0; c < 300; c++) begin
      m4 = 1'($urandom); s4 = 2'($urandom); v4 = 4'($urandom); d4 = $urandom; or4 = ($urandom % 4) != 0;
      m3 = 1'($urandom); s3 = 2'($urandom); v3 = 3'($urandom); d3 = 24'($urandom); or3 = ($urandom % 3) != 0;
      #1;
      e4 = exp_rdy(0); e3 = exp_rdy(1);
      checks++; if (rdy4 !== e4[3:0]) begin errors++; $display("FAIL rnd_rdy4[%0d]: got %b expected %b", c, rdy4, e4[3:0]); end
      checks++; if (rdy3 !== e3[2:0]) begin errors++; $display("FAIL rnd_rdy3[%0d]: got %b expected %b", c, rdy3, e3[2:0]); end
      tick();
      checks++; if (ov4 !== e_valid[0] || (e_valid[0] && (od4 !== e_data[0] || oc4 !== 2'(e_ch[0])))) begin
        errors++; $display("FAIL rnd_out4[%0d]: got %b/%h/%0d expected %b/%h/%0d", c, ov4, od4, oc4, e_valid[0], e_data[0], e_ch[0]);
      end
      checks++; if (ov3 !== e_valid[1] || (e_valid[1] && (od3 !== e_data[1] || oc3 !== 2'(e_ch[1])))) begin
        errors++; $display("FAIL rnd_out3[%0d]: got %b/%h/%0d expected %b/%h/%0d", c, ov3, od3, oc3, e_valid[1], e_data[1], e_ch[1]);
      end
    end
  endtask

  task automatic test_reset_mid();
    m4 = 0; s4 = 2'd0; v4 = 4'b0001; d4 = $urandom; or4 = 1;
    v3 = '0; or3 = 1;
    tick();
    or4 = 0; v4 = '0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (ov4 !== 1'b0 || od4 !== 8'h00 || oc4 !== 2'd0) begin
      errors++; $display("FAIL midreset_out: got %b/%h/%0d expected 0/00/0", ov4, od4, oc4);
    end
    model_reset();
    #1;
    rst_n = 1'b1;
    tick();
    checks++; if (ov4 !== 1'b0) begin errors++; $display("FAIL midreset_after: got %b expected 0", ov4); end
  endtask

`ifdef MUX_RR_STREAM_CNT_EN
  task automatic test_counters();
    rst_n = 1'b0;
    model_reset();
    #2;
    rst_n = 1'b1;
    m4 = 0; s4 = 2'd1; v4 = 4'b0010; or4 = 1; v3 = '0; or3 = 1;
    for (int c = 0; c < 1000; c++) begin d4 = $urandom; tick(); end
    checks++; if (cnt4[31:16] !== 16'd1000) begin errors++; $display("FAIL cnt_1000: got %0d expected 1000", cnt4[31:16]); end
    for (int c = 1000; c < 70000; c++) begin d4 = $urandom; tick(); end
    checks++; if (cnt4[31:16] !== 16'hFFFF) begin errors++; $display("FAIL cnt_sat: got %h expected ffff", cnt4[31:16]); end
    checks++; if (cnt4[15:0] !== 16'h0 || cnt4[63:32] !== 32'h0) begin errors++; $display("FAIL cnt_others: got %h expected 0 outside ch1", cnt4); end
    checks++; if (cnt3 !== 48'h0) begin errors++; $display("FAIL cnt_idle3: got %h expected 0", cnt3); end
  endtask
`endif

  initial begin
    test_reset();
    test_fixed();
    test_rr_fair();
    test_sparse();
    test_backpressure();
    test_nch3();
    test_random();
    test_reset_mid();
`ifdef MUX_RR_STREAM_CNT_EN
    test_counters();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
